// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU arbiter slice.
//   alu_op_t    - 3-bit ALU select S, with the eight op constants
//   arb_state_t - arbiter FSM states
//   grant_t     - result of the round-robin grant decision
//   ALU_WIDTH   - operand/result width of alu_32_bit
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'b000;
  localparam alu_op_t OP_SUB = 3'b001;
  localparam alu_op_t OP_AND = 3'b010;
  localparam alu_op_t OP_OR  = 3'b011;
  localparam alu_op_t OP_XOR = 3'b100;
  localparam alu_op_t OP_NOT = 3'b101;
  localparam alu_op_t OP_SLL = 3'b110;
  localparam alu_op_t OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic gnt;  // some requester is granted
    logic who;  // index of the granted requester
  } grant_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: command and response channels of both requesters.
//   reqN_valid/ready/op/a/b - command handshake from requester N
//   rspN_valid/ready/data   - result handshake back to requester N
//   master - requester side, slave - arbiter side
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/alu_32_bit.sv
// alu_32_bit: purely combinational ALU.
//   S - op select (alu_op_t), A/B - operands, Y - result
//   Arithmetic wraps modulo 2^WIDTH; shifts move A by one bit, zero-filled.
module alu_32_bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_t          S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y
);
  always_comb begin
    Y = '0;
    case (S)
      OP_ADD:  Y = A + B;
      OP_SUB:  Y = A - B;
      OP_AND:  Y = A & B;
      OP_OR:   Y = A | B;
      OP_XOR:  Y = A ^ B;
      OP_NOT:  Y = ~A;
      OP_SLL:  Y = {A[WIDTH-2:0], 1'b0};
      OP_SRL:  Y = {1'b0, A[WIDTH-1:1]};
      default: Y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu_32_bit between two requesters.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_arbiter_if.slave: both command channels and both
//           response channels
// One command is in flight at a time: IDLE grants (round-robin on a
// tie), EXEC runs the ALU on registered operands, RESP holds the result
// for the owner until it is taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus
);

  // On a tie the requester that was not granted last wins.
  function automatic grant_t arb_grant(input logic v0, input logic v1,
                                       input logic last);
    grant_t g;
    g.gnt = v0 | v1;
    g.who = (v0 && v1) ? ~last : v1;
    return g;
  endfunction

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] alu_y;
  grant_t           gnt;

  assign gnt = arb_grant(bus.req0_valid, bus.req1_valid, last_grant_q);

  // The ALU only ever sees the registered operands.
  alu_32_bit #(.WIDTH(WIDTH)) u_alu (
    .S (op_q),
    .A (a_q),
    .B (b_q),
    .Y (alu_y)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is combinational from valid, so gate it with rst_n to keep
        // it low while reset is held.
        if (gnt.gnt && rst_n) begin
          owner_d      = gnt.who;
          last_grant_d = gnt.who;
          state_d      = EXEC;
          if (gnt.who) begin
            bus.req1_ready = 1'b1;
            op_d           = bus.req1_op;
            a_d            = bus.req1_a;
            b_d            = bus.req1_b;
          end else begin
            bus.req0_ready = 1'b1;
            op_d           = bus.req0_op;
            a_d            = bus.req0_a;
            b_d            = bus.req0_b;
          end
        end
      end
      // Operand registers -> ALU -> result_q
      EXEC: begin
        result_d = alu_y;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q) begin
          bus.rsp1_valid = 1'b1;
          if (bus.rsp1_ready) state_d = IDLE;
        end else begin
          bus.rsp0_valid = 1'b1;
          if (bus.rsp0_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Both data outputs carry result_q; only the owner's valid qualifies it.
  assign bus.rsp0_data = result_q;
  assign bus.rsp1_data = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
    end
  end

endmodule
